// File: rtl/branch_resolve.sv
// Branch outcome resolution and registered IF redirect request for the pipelined CPU.
// Optional statistics counters are compiled in when BRANCH_STAT_EN is defined.
module branch_resolve #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             equal,
  input  logic             greater,
  input  logic             less,
  input  logic             rs_neg,
  input  logic             rs_zero,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  input  logic             if_ready,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        err_q, err_d;

  logic        ev;
  logic        taken;
  logic        illegal_br;
  logic [31:0] target;

  assign ev         = br_valid & ~stall & (state_q == IDLE);
  assign illegal_br = br_valid & ~stall & (state_q == PEND);
  assign target     = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (br_type)
      3'd0: taken = equal;
      3'd1: taken = ~equal;
      3'd2: taken = rs_neg | rs_zero;
      3'd3: taken = ~rs_neg & ~rs_zero;
      3'd4: taken = rs_neg;
      3'd5: taken = ~rs_neg;
      3'd6: taken = greater;
      3'd7: taken = less;
      default: taken = 1'b0;
    endcase
  end

  // A branch arriving while a redirect is pending is dropped, never evaluated.
  always_comb begin
    state_d       = state_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (ev && taken) begin
          state_d       = PEND;
          redirect_d    = 1'b1;
          redirect_pc_d = target;
        end
      end
      PEND: begin
        if (illegal_br) begin
          err_d = 1'b1;
        end
        if (if_ready) begin
          state_d    = IDLE;
          redirect_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        redirect_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign err         = err_q;

`ifdef BRANCH_STAT_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (ev) begin
      if (taken) begin
        taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ntaken_cnt_d = ntaken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`else
  assign taken_cnt  = '0;
  assign ntaken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: random and directed branches against a value-level model.
module tb_branch_resolve;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             br_valid = 1'b0;
  logic [2:0]       br_type = 3'd0;
  logic             equal = 1'b0;
  logic             greater = 1'b0;
  logic             less = 1'b0;
  logic             rs_neg = 1'b0;
  logic             rs_zero = 1'b0;
  logic [31:0]      pc_id = 32'd0;
  logic [15:0]      imm16 = 16'd0;
  logic             if_ready = 1'b0;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             err;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
    .equal(equal), .greater(greater), .less(less), .rs_neg(rs_neg), .rs_zero(rs_zero),
    .pc_id(pc_id), .imm16(imm16), .if_ready(if_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .err(err), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    logic             redirect;
    logic [31:0]      pc;
    logic             err;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] nc;
  } exp_t;

  typedef struct {
    int          tag;
    int          field;
    logic [31:0] val;
  } dir_t;

  exp_t exp_q[$];
  dir_t dir_q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit               m_pend = 1'b0;
  logic [31:0]      m_pc = 32'd0;
  bit               m_err = 1'b0;
  logic [CNT_W-1:0] m_tc = '0;
  logic [CNT_W-1:0] m_nc = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic bit branch_taken(input logic [2:0] ty, input logic [31:0] d1, input logic [31:0] d2);
    case (ty)
      3'd0: return d1 == d2;
      3'd1: return d1 != d2;
      3'd2: return $signed(d1) <= 0;
      3'd3: return $signed(d1) > 0;
      3'd4: return $signed(d1) < 0;
      3'd5: return $signed(d1) >= 0;
      3'd6: return d1 > d2;
      default: return d1 < d2;
    endcase
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  task automatic drive(input bit rst, input bit stl, input bit bv, input logic [2:0] ty,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                       input logic [15:0] imm, input bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; stall = stl; br_valid = bv; br_type = ty;
    equal = (d1 == d2); greater = (d1 > d2); less = (d1 < d2);
    rs_neg = d1[31]; rs_zero = (d1 == 32'd0);
    pc_id = pc; imm16 = imm; if_ready = rdy;
    if (rst) begin
      m_pend = 1'b0; m_pc = 32'd0; m_err = 1'b0; m_tc = '0; m_nc = '0;
    end else if (!m_pend) begin
      if (bv && !stl) begin
        if (branch_taken(ty, d1, d2)) begin
          m_pend = 1'b1;
          m_pc = branch_target(pc, imm);
          m_tc = m_tc + 1'b1;
        end else begin
          m_nc = m_nc + 1'b1;
        end
      end
    end else begin
      if (bv && !stl) m_err = 1'b1;
      if (rdy) m_pend = 1'b0;
    end
    e.tag = edge_cnt + 1;
    e.redirect = m_pend;
    e.pc = m_pc;
    e.err = m_err;
`ifdef BRANCH_STAT_EN
    e.tc = m_tc;
    e.nc = m_nc;
`else
    e.tc = '0;
    e.nc = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, $urandom_range(0, 1), 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom, 16'($urandom), rdy);
  endtask

  // field: 0 redirect, 1 redirect_pc, 2 err; checked against the outputs of the last edge
  task automatic expect_now(input int field, input logic [31:0] val);
    dir_t d;
    d.tag = edge_cnt;
    d.field = field;
    d.val = val;
    dir_q.push_back(d);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, req);
    end
  endtask

  exp_t mon_e;
  dir_t mon_d;
  logic [31:0] mon_act;
  string mon_name;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
      mon_e = exp_q.pop_front();
      if (mon_e.tag < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL stale_expectation tag %0d at edge %0d", mon_e.tag, edge_cnt);
      end else begin
        cmp("redirect", {31'd0, redirect}, {31'd0, mon_e.redirect});
        cmp("redirect_pc", redirect_pc, mon_e.pc);
        cmp("err", {31'd0, err}, {31'd0, mon_e.err});
        cmp("taken_cnt", taken_cnt, mon_e.tc);
        cmp("ntaken_cnt", ntaken_cnt, mon_e.nc);
      end
    end
    while (dir_q.size() > 0 && dir_q[0].tag <= edge_cnt) begin
      mon_d = dir_q.pop_front();
      case (mon_d.field)
        0: begin mon_act = {31'd0, redirect}; mon_name = "directed_redirect"; end
        1: begin mon_act = redirect_pc; mon_name = "directed_redirect_pc"; end
        default: begin mon_act = {31'd0, err}; mon_name = "directed_err"; end
      endcase
      cmp(mon_name, mon_act, mon_d.val);
      $display("directed %s edge %0d value %h", mon_name, edge_cnt, mon_act);
    end
  end

  initial begin
    logic [31:0] d1, d2;
    // reset held two cycles
    drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    expect_now(0, 0); expect_now(1, 0); expect_now(2, 0);
    // beq taken, accepted immediately
    drive(0, 0, 1, 3'd0, 32'd5, 32'd5, 32'h0000_3000, 16'h0004, 1);
    idle(1);
    expect_now(0, 1); expect_now(1, 32'h0000_3014);
    idle(1);
    expect_now(0, 0);
    // bne not taken
    drive(0, 0, 1, 3'd1, 32'd7, 32'd7, 32'h0000_2000, 16'h0010, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      expect_now(0, 0);
    end
    // bltz backward-to-self target, IF not ready for 4 cycles
    drive(0, 0, 1, 3'd4, 32'h8000_0001, 32'd0, 32'h0000_3010, 16'hFFFF, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      expect_now(0, 1); expect_now(1, 32'h0000_3010);
    end
    idle(1);
    idle(0);
    expect_now(0, 0);
    // illegal branch while pending sets sticky err
    drive(0, 0, 1, 3'd0, 32'd9, 32'd9, 32'h0000_0100, 16'h0010, 0);
    drive(0, 0, 1, 3'd6, 32'd9, 32'd1, 32'h0000_0200, 16'h0020, 0);
    idle(0);
    expect_now(2, 1); expect_now(1, 32'h0000_0144);
    idle(1);
    expect_now(2, 1);
    idle(0);
    expect_now(2, 1); expect_now(0, 0);
    drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    idle(0);
    expect_now(2, 0); expect_now(0, 0);
    // bgtu stalled two cycles
    drive(0, 1, 1, 3'd6, 32'd5, 32'd3, 32'h0000_4000, 16'h0008, 1);
    drive(0, 1, 1, 3'd6, 32'd5, 32'd3, 32'h0000_4000, 16'h0008, 1);
    expect_now(0, 0);
    drive(0, 0, 1, 3'd6, 32'd5, 32'd3, 32'h0000_4000, 16'h0008, 1);
    expect_now(0, 0);
    idle(1);
    expect_now(0, 1); expect_now(1, 32'h0000_4024);
    idle(1);
    expect_now(0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d2 = $urandom;
      case ($urandom_range(0, 3))
        0: d1 = 32'd0;
        1: d1 = d2;
        default: d1 = $urandom;
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), d1, d2, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            16'($urandom), $urandom_range(0, 9) < 4);
    end
    idle(1);
    idle(1);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
